// File: rtl/ltssm_timer_bank_if.sv
// ltssm_timer_bank_if: control/status bundle for ltssm_timer_bank.
// LTSSM_TIMER_RDBK_EN adds the RdSel/RdRemain readback signals.
interface ltssm_timer_bank_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 32
);
    logic [2:0]          Gen;
    logic [NUM_CH-1:0]   Enable;
    logic [NUM_CH-1:0]   Start;
    logic [NUM_CH-1:0]   Stop;
    logic [NUM_CH-1:0]   Periodic;
    logic [3*NUM_CH-1:0] IntervalCode;
    logic [NUM_CH-1:0]   TimeOut;
    logic [NUM_CH-1:0]   TimeOutPulse;
    logic [NUM_CH-1:0]   Running;
`ifdef LTSSM_TIMER_RDBK_EN
    logic [3:0]          RdSel;
    logic [WIDTH-1:0]    RdRemain;
`endif
    modport master (
        output Gen, Enable, Start, Stop, Periodic, IntervalCode,
`ifdef LTSSM_TIMER_RDBK_EN
        output RdSel,
        input  RdRemain,
`endif
        input  TimeOut, TimeOutPulse, Running
    );
    modport slave (
        input  Gen, Enable, Start, Stop, Periodic, IntervalCode,
`ifdef LTSSM_TIMER_RDBK_EN
        input  RdSel,
        output RdRemain,
`endif
        output TimeOut, TimeOutPulse, Running
    );
endinterface

// File: rtl/ltssm_timer_bank.sv
// ltssm_timer_bank: NUM_CH independent LTSSM/equaliser interval timers sharing Pclk, Gen and PIPE width.
// Define LTSSM_TIMER_RDBK_EN to add the RdSel/RdRemain remaining-time readback.
module ltssm_timer_bank #(
    parameter int NUM_CH         = 4,
    parameter int WIDTH          = 32,
    parameter int SCALE_DIV      = 100,
    parameter int GEN1_PIPEWIDTH = 8,
    parameter int GEN2_PIPEWIDTH = 8,
    parameter int GEN3_PIPEWIDTH = 8,
    parameter int GEN4_PIPEWIDTH = 8,
    parameter int GEN5_PIPEWIDTH = 8
) (
    input logic               Pclk,
    input logic               Reset,
    ltssm_timer_bank_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
    localparam logic [63:0] MAX_IVL = {{(64-WIDTH){1'b0}}, {WIDTH{1'b1}}};
    localparam logic [63:0] BASE [8] = '{
        64'd0,
        64'(750000 / SCALE_DIV),
        64'(1500000 / SCALE_DIV),
        64'(3000000 / SCALE_DIV),
        64'(125000 / SCALE_DIV),
        64'(500000 / SCALE_DIV),
        64'(62500 / SCALE_DIV),
        64'(6250000 / SCALE_DIV)
    };

    function automatic logic [1:0] wsh(input int pw);
        return pw == 32 ? 2'd0 : pw == 16 ? 2'd1 : 2'd2;
    endfunction

    logic [2:0] gen_idx;
    logic [1:0] width_shift;
    logic [3:0] shift;

    // Illegal Gen codes fall back to Gen1 scaling.
    always_comb begin
        gen_idx     = (bus.Gen >= 3'd1 && bus.Gen <= 3'd5) ? bus.Gen - 3'd1 : 3'd0;
        width_shift = gen_idx == 3'd0 ? wsh(GEN1_PIPEWIDTH) :
                      gen_idx == 3'd1 ? wsh(GEN2_PIPEWIDTH) :
                      gen_idx == 3'd2 ? wsh(GEN3_PIPEWIDTH) :
                      gen_idx == 3'd3 ? wsh(GEN4_PIPEWIDTH) : wsh(GEN5_PIPEWIDTH);
        shift       = {1'b0, gen_idx} + {2'b00, width_shift};
    end

`ifdef LTSSM_TIMER_RDBK_EN
    logic [WIDTH-1:0] remain [NUM_CH];
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           state_q;
        logic [WIDTH-1:0] cnt_q, ivl_q, ivl_d;
        logic [63:0]      raw;
        logic             timeout_q, pulse_q, running_q, expire;
        assign raw    = BASE[bus.IntervalCode[3*i +: 3]] << shift;
        assign ivl_d  = raw > MAX_IVL ? MAX_IVL[WIDTH-1:0] : raw[WIDTH-1:0];
        // A zero interval expires on the first edge after Start whatever Enable says.
        assign expire = state_q == RUN && (ivl_q == '0 || (bus.Enable[i] && cnt_q == ivl_q - WIDTH'(1)));
        always_ff @(posedge Pclk) begin
            if (!Reset) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                ivl_q     <= '0;
                timeout_q <= 1'b0;
                pulse_q   <= 1'b0;
                running_q <= 1'b0;
            end else if (bus.Start[i]) begin
                state_q   <= RUN;
                cnt_q     <= '0;
                ivl_q     <= ivl_d;
                timeout_q <= 1'b0;
                pulse_q   <= 1'b0;
                running_q <= 1'b1;
            end else if (bus.Stop[i]) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                timeout_q <= 1'b0;
                pulse_q   <= 1'b0;
                running_q <= 1'b0;
            end else if (expire) begin
                cnt_q   <= '0;
                pulse_q <= 1'b1;
                if (!bus.Periodic[i]) begin
                    state_q   <= EXPIRED;
                    timeout_q <= 1'b1;
                    running_q <= 1'b0;
                end
            end else begin
                pulse_q <= 1'b0;
                if (state_q == RUN && bus.Enable[i]) cnt_q <= cnt_q + WIDTH'(1);
            end
        end
        assign bus.TimeOut[i]      = timeout_q;
        assign bus.TimeOutPulse[i] = pulse_q;
        assign bus.Running[i]      = running_q;
`ifdef LTSSM_TIMER_RDBK_EN
        assign remain[i] = running_q ? ivl_q - cnt_q : '0;
`endif
    end

`ifdef LTSSM_TIMER_RDBK_EN
    logic [WIDTH-1:0] rd_d, rd_q;
    always_comb begin
        rd_d = '0;
        for (int c = 0; c < NUM_CH; c++) rd_d = bus.RdSel == 4'(c) ? remain[c] : rd_d;
    end
    always_ff @(posedge Pclk) rd_q <= !Reset ? '0 : rd_d;
    assign bus.RdRemain = rd_q;
`endif
endmodule

// File: tb/tb_ltssm_timer_bank.sv
// tb_ltssm_timer_bank: directed and randomized checks of ltssm_timer_bank
// against a deadline-countdown reference model.
module tb_ltssm_timer_bank;
    localparam int NCH = 4;
    localparam int W   = 32;
    localparam int SD  = 1000;

    logic Pclk  = 1'b0;
    logic Reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   codes [6] = '{0, 6, 6, 6, 4, 5};

    ltssm_timer_bank_if #(.NUM_CH(NCH), .WIDTH(W))  bus ();
    ltssm_timer_bank_if #(.NUM_CH(1),   .WIDTH(12)) sbus ();

    ltssm_timer_bank #(.NUM_CH(NCH), .WIDTH(W), .SCALE_DIV(SD), .GEN3_PIPEWIDTH(16), .GEN4_PIPEWIDTH(32))
        dut (.Pclk(Pclk), .Reset(Reset), .bus(bus));
    ltssm_timer_bank #(.NUM_CH(1), .WIDTH(12), .SCALE_DIV(SD))
        dut_s (.Pclk(Pclk), .Reset(Reset), .bus(sbus));

    always #5 Pclk = ~Pclk;

    // Model: each running channel holds the number of enabled edges left until expiry.
    int             m_st   [NCH];
    longint         m_left [NCH];
    longint         m_ivl  [NCH];
    logic [NCH-1:0] m_pulse;
    longint         m_rd;

    function automatic longint ivl_of(input logic [2:0] gen, input logic [2:0] code);
        int     ms [8];
        int     pw [5];
        int     g, ws;
        longint v, mx;
        ms = '{0, 12, 24, 48, 2, 8, 1, 100};
        pw = '{8, 8, 16, 32, 8};
        g  = (gen >= 3'd1 && gen <= 3'd5) ? int'(gen) - 1 : 0;
        ws = pw[g] == 32 ? 0 : pw[g] == 16 ? 1 : 2;
        v  = (longint'(ms[code]) * 62500 / SD) * (longint'(1) << (g + ws));
        mx = (longint'(1) << W) - 1;
        return v > mx ? mx : v;
    endfunction

    function automatic logic [NCH-1:0] st_vec(input int s);
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_st[c] == s;
        return v;
    endfunction

    task automatic step();
        m_rd = 0;
`ifdef LTSSM_TIMER_RDBK_EN
        if (Reset && bus.RdSel < NCH && m_st[bus.RdSel] == 1) m_rd = m_left[bus.RdSel];
`endif
        for (int c = 0; c < NCH; c++) begin
            m_pulse[c] = 1'b0;
            if (!Reset) begin
                m_st[c] = 0; m_left[c] = 0; m_ivl[c] = 0;
            end else if (bus.Start[c]) begin
                m_ivl[c] = ivl_of(bus.Gen, bus.IntervalCode[3*c +: 3]);
                m_left[c] = m_ivl[c];
                m_st[c] = 1;
            end else if (bus.Stop[c]) begin
                m_st[c] = 0;
            end else if (m_st[c] == 1 && (m_left[c] == 0 || bus.Enable[c])) begin
                if (m_left[c] > 0) m_left[c]--;
                if (m_left[c] == 0) begin
                    m_pulse[c] = 1'b1;
                    if (bus.Periodic[c]) m_left[c] = m_ivl[c];
                    else m_st[c] = 2;
                end
            end
        end
        @(posedge Pclk);
        @(negedge Pclk);
    endtask

    task automatic start_ch(input int ch);
        bus.Start[ch] = 1'b1;
        step();
        bus.Start[ch] = 1'b0;
    endtask

    task automatic stop_ch(input int ch);
        bus.Stop[ch] = 1'b1;
        step();
        bus.Stop[ch] = 1'b0;
    endtask

    task automatic run_until_pulse(input int ch, input int limit, output int n);
        n = 0;
        do begin step(); n++; end while (!bus.TimeOutPulse[ch] && n < limit);
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        bus.Start = '1;
        bus.Enable = '1;
        repeat (3) step();
        bus.Start = '0;
        checks++; if (bus.TimeOut !== '0) begin errors++; $display("FAIL reset_timeout got %b exp 0", bus.TimeOut); end
        checks++; if (bus.TimeOutPulse !== '0) begin errors++; $display("FAIL reset_pulse got %b exp 0", bus.TimeOutPulse); end
        checks++; if (bus.Running !== '0) begin errors++; $display("FAIL reset_running got %b exp 0", bus.Running); end
`ifdef LTSSM_TIMER_RDBK_EN
        checks++; if (bus.RdRemain !== '0) begin errors++; $display("FAIL reset_rdremain got %0d exp 0", bus.RdRemain); end
`endif
        Reset = 1'b1;
        step();
        checks++; if (bus.Running !== '0 || sbus.Running !== 1'b0) begin errors++; $display("FAIL post_reset_idle got %b/%b exp 0", bus.Running, sbus.Running); end
    endtask

    task automatic test_oneshot();
        int n;
        bus.Gen = 3'd1;
        bus.Periodic[0] = 1'b0;
        bus.IntervalCode[2:0] = 3'b001;
        start_ch(0);
        run_until_pulse(0, 4000, n);
        checks++; if (n !== 3000) begin errors++; $display("FAIL oneshot_latency got %0d exp 3000", n); end
        checks++; if (bus.TimeOut[0] !== 1'b1 || bus.Running[0] !== 1'b0) begin errors++; $display("FAIL oneshot_expired got to=%b run=%b exp to=1 run=0", bus.TimeOut[0], bus.Running[0]); end
        repeat (20) step();
        checks++; if (bus.TimeOut[0] !== 1'b1 || bus.TimeOutPulse[0] !== 1'b0) begin errors++; $display("FAIL oneshot_hold got to=%b pl=%b exp to=1 pl=0", bus.TimeOut[0], bus.TimeOutPulse[0]); end
        stop_ch(0);
        checks++; if (bus.TimeOut[0] !== 1'b0) begin errors++; $display("FAIL oneshot_stop got %b exp 0", bus.TimeOut[0]); end
    endtask

    task automatic test_periodic();
        int n;
        bus.Gen = 3'd5;
        bus.Periodic[1] = 1'b1;
        bus.IntervalCode[5:3] = 3'b100;
        start_ch(1);
        for (int p = 0; p < 3; p++) begin
            run_until_pulse(1, 9000, n);
            checks++; if (n !== 8000) begin errors++; $display("FAIL periodic_period%0d got %0d exp 8000", p, n); end
            checks++; if (bus.TimeOut[1] !== 1'b0 || bus.Running[1] !== 1'b1) begin errors++; $display("FAIL periodic_state%0d got to=%b run=%b exp to=0 run=1", p, bus.TimeOut[1], bus.Running[1]); end
        end
        stop_ch(1);
        bus.Periodic[1] = 1'b0;
        bus.Gen = 3'd1;
    endtask

    task automatic test_pause_gen();
        int n;
        bus.Gen = 3'd1;
        bus.IntervalCode[8:6] = 3'b010;
        start_ch(2);
        repeat (2000) step();
        bus.Enable[2] = 1'b0;
        repeat (1000) step();
        checks++; if (bus.Running[2] !== 1'b1 || bus.TimeOutPulse[2] !== 1'b0) begin errors++; $display("FAIL pause_frozen got run=%b pl=%b exp run=1 pl=0", bus.Running[2], bus.TimeOutPulse[2]); end
        bus.Enable[2] = 1'b1;
        bus.Gen = 3'd5;
        run_until_pulse(2, 6000, n);
        checks++; if (n !== 4000) begin errors++; $display("FAIL pause_latency got %0d exp 4000 (7000 total)", 3000 + n); end
        bus.Gen = 3'd1;
        stop_ch(2);
    endtask

    task automatic test_zero_restart();
        int n;
        bus.IntervalCode[11:9] = 3'b000;
        bus.Enable[3] = 1'b0;
        start_ch(3);
        checks++; if (bus.Running[3] !== 1'b1 || bus.TimeOut[3] !== 1'b0) begin errors++; $display("FAIL zero_start got run=%b to=%b exp run=1 to=0", bus.Running[3], bus.TimeOut[3]); end
        step();
        checks++; if (bus.TimeOutPulse[3] !== 1'b1 || bus.TimeOut[3] !== 1'b1) begin errors++; $display("FAIL zero_expiry got pl=%b to=%b exp 1/1", bus.TimeOutPulse[3], bus.TimeOut[3]); end
        start_ch(3);
        checks++; if (bus.TimeOut[3] !== 1'b0 || bus.TimeOutPulse[3] !== 1'b0) begin errors++; $display("FAIL restart_expired got to=%b pl=%b exp 0/0", bus.TimeOut[3], bus.TimeOutPulse[3]); end
        bus.Enable[3] = 1'b1;
        stop_ch(3);
        bus.IntervalCode[2:0] = 3'b001;
        start_ch(0);
        repeat (500) step();
        bus.Start[0] = 1'b1;
        bus.Stop[0]  = 1'b1;
        step();
        bus.Start[0] = 1'b0;
        bus.Stop[0]  = 1'b0;
        checks++; if (bus.Running[0] !== 1'b1) begin errors++; $display("FAIL start_stop_run got %b exp 1", bus.Running[0]); end
        run_until_pulse(0, 4000, n);
        checks++; if (n !== 3000) begin errors++; $display("FAIL start_stop_latency got %0d exp 3000", n); end
        stop_ch(0);
    endtask

    task automatic test_stop_expiry();
        bus.IntervalCode[2:0] = 3'b001;
        start_ch(0);
        repeat (2999) step();
        checks++; if (bus.Running[0] !== 1'b1 || bus.TimeOutPulse[0] !== 1'b0) begin errors++; $display("FAIL pre_expiry got run=%b pl=%b exp 1/0", bus.Running[0], bus.TimeOutPulse[0]); end
        stop_ch(0);
        checks++; if (bus.TimeOutPulse[0] !== 1'b0 || bus.Running[0] !== 1'b0 || bus.TimeOut[0] !== 1'b0) begin errors++; $display("FAIL stop_on_expiry got pl=%b run=%b to=%b exp 0/0/0", bus.TimeOutPulse[0], bus.Running[0], bus.TimeOut[0]); end
        step();
        checks++; if (bus.TimeOutPulse[0] !== 1'b0) begin errors++; $display("FAIL stop_late_pulse got %b exp 0", bus.TimeOutPulse[0]); end
    endtask

    task automatic test_reset_mid();
        bus.IntervalCode = {NCH{3'b110}};
        bus.Periodic = '1;
        bus.Start = '1;
        step();
        bus.Start = '0;
        repeat (247) step();
        checks++; if (bus.Running !== '1) begin errors++; $display("FAIL mid_running got %b exp 1111", bus.Running); end
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        checks++; if (bus.Running !== '0 || bus.TimeOut !== '0 || bus.TimeOutPulse !== '0) begin errors++; $display("FAIL reset_mid got run=%b to=%b pl=%b exp 0", bus.Running, bus.TimeOut, bus.TimeOutPulse); end
        bus.Periodic = '0;
        step();
    endtask

`ifdef LTSSM_TIMER_RDBK_EN
    task automatic test_readback();
        bus.Gen = 3'd1;
        bus.RdSel = 4'd0;
        bus.IntervalCode[2:0] = 3'b001;
        start_ch(0);
        repeat (100) step();
        checks++; if (bus.RdRemain !== W'(m_rd)) begin errors++; $display("FAIL rd_model got %0d exp %0d", bus.RdRemain, m_rd); end
        checks++; if (bus.RdRemain < 2900 || bus.RdRemain > 2901) begin errors++; $display("FAIL rd_value got %0d exp 2900..2901", bus.RdRemain); end
        bus.RdSel = 4'd7;
        step();
        checks++; if (bus.RdRemain !== '0) begin errors++; $display("FAIL rd_out_of_range got %0d exp 0", bus.RdRemain); end
        bus.RdSel = 4'd0;
        stop_ch(0);
        step();
        checks++; if (bus.RdRemain !== '0) begin errors++; $display("FAIL rd_idle got %0d exp 0", bus.RdRemain); end
    endtask
`endif

    task automatic test_saturation();
        int n;
        sbus.Gen = 3'd5;
        sbus.IntervalCode = 3'b111;
        sbus.Start = 1'b1;
        step();
        sbus.Start = 1'b0;
        n = 0;
        do begin step(); n++; end while (!sbus.TimeOutPulse[0] && n < 5000);
        checks++; if (n !== 4095) begin errors++; $display("FAIL saturation_latency got %0d exp 4095", n); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 199) == 0) bus.Gen = 3'($urandom_range(0, 7));
            for (int c = 0; c < NCH; c++) begin
                bus.Enable[c] = $urandom_range(0, 7) != 0;
                bus.Start[c] = $urandom_range(0, 59) == 0;
                bus.Stop[c] = $urandom_range(0, 149) == 0;
                bus.Periodic[c] = 1'($urandom_range(0, 1));
                bus.IntervalCode[3*c +: 3] = 3'(codes[$urandom_range(0, 5)]);
            end
`ifdef LTSSM_TIMER_RDBK_EN
            bus.RdSel = 4'($urandom_range(0, 7));
`endif
            Reset = $urandom_range(0, 999) != 0;
            step();
            checks++; if (bus.TimeOut !== st_vec(2)) begin errors++; $display("FAIL rand_timeout cyc %0d got %b exp %b", k, bus.TimeOut, st_vec(2)); end
            checks++; if (bus.Running !== st_vec(1)) begin errors++; $display("FAIL rand_running cyc %0d got %b exp %b", k, bus.Running, st_vec(1)); end
            checks++; if (bus.TimeOutPulse !== m_pulse) begin errors++; $display("FAIL rand_pulse cyc %0d got %b exp %b", k, bus.TimeOutPulse, m_pulse); end
`ifdef LTSSM_TIMER_RDBK_EN
            checks++; if (bus.RdRemain !== W'(m_rd)) begin errors++; $display("FAIL rand_rdremain cyc %0d got %0d exp %0d", k, bus.RdRemain, m_rd); end
`endif
        end
        Reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Gen = 3'd1; bus.Enable = '0; bus.Start = '0; bus.Stop = '0;
        bus.Periodic = '0; bus.IntervalCode = '0;
        sbus.Gen = 3'd1; sbus.Enable = 1'b1; sbus.Start = 1'b0; sbus.Stop = 1'b0;
        sbus.Periodic = 1'b0; sbus.IntervalCode = '0;
`ifdef LTSSM_TIMER_RDBK_EN
        bus.RdSel = 4'd0;
        sbus.RdSel = 4'd0;
`endif
        @(negedge Pclk);
        test_reset();
        test_oneshot();
        test_periodic();
        test_pause_gen();
        test_zero_restart();
        test_stop_expiry();
        test_reset_mid();
`ifdef LTSSM_TIMER_RDBK_EN
        test_readback();
`endif
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
